// File: rtl/fir_decimator_out.sv
// Decimating output stage: boxcar-sums 2**LOG2_N filter samples, rounds, scales
// and saturates to OUT_W bits, then buffers results in a small valid/ready FIFO.
module fir_decimator_out #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int LOG2_N    = 2,
  parameter int OUT_SHIFT = 2,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     saturated,
  input  logic                     clr_flags
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = IN_W + LOG2_N;
  localparam int W     = ACC_W + 1;
  localparam int S     = LOG2_N + OUT_SHIFT;
  localparam int PH_W  = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int RS    = (S > 0) ? S - 1 : 0;

  localparam logic [PH_W-1:0]     LAST_PH = PH_W'(N - 1);
  localparam logic signed [W-1:0] RND_C   = (S > 0) ? ({{(W-1){1'b0}}, 1'b1} << RS) : {W{1'b0}};
  localparam logic signed [W-1:0] MAX_W   = W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] MIN_W   = ~MAX_W;

  // Round half toward +inf, shift, clip; returns {clipped, value}. The add is
  // one bit wider than the accumulator so it can never wrap.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] sum);
    logic signed [W-1:0] wide;
    logic signed [W-1:0] r;
    wide = W'(sum) + RND_C;
    r    = wide >>> S;
    if (r > MAX_W) begin
      scale_sat = {1'b1, MAX_W[OUT_W-1:0]};
    end else if (r < MIN_W) begin
      scale_sat = {1'b1, MIN_W[OUT_W-1:0]};
    end else begin
      scale_sat = {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  logic [PH_W-1:0]         phase_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] in_ext_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                    stage_valid_r;
  logic signed [ACC_W-1:0] stage_sum_r;
  logic                    sat_s;
  logic [OUT_W-1:0]        res_s;
  logic [OUT_W-1:0]        mem_r [DEPTH];
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [LW-1:0]           level_r;
  logic [LW-1:0]           level_nxt_s;
  logic                    out_valid_r;
  logic                    pop_s;
  logic                    full_s;
  logic                    wr_en_s;
  logic                    drop_s;
  logic                    overflow_r;
  logic                    saturated_r;

  // Running block sum; phase 0 starts a fresh block.
  always_comb begin
    in_ext_s = ACC_W'($signed(in_data));
    if (phase_r == {PH_W{1'b0}}) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = acc_r;
    end
    sum_s = base_s + in_ext_s;
  end

  // Phase counter and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= {PH_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
    end else if (in_valid) begin
      acc_r <= sum_s;
      if (phase_r == LAST_PH) begin
        phase_r <= {PH_W{1'b0}};
      end else begin
        phase_r <= phase_r + PH_W'(1);
      end
    end
  end

  // Scale stage: captures the completed block sum for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_r <= 1'b0;
      stage_sum_r   <= {ACC_W{1'b0}};
    end else begin
      stage_valid_r <= in_valid && (phase_r == LAST_PH);
      if (in_valid && (phase_r == LAST_PH)) begin
        stage_sum_r <= sum_s;
      end
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO.
  always_comb begin
    {sat_s, res_s} = scale_sat(stage_sum_r);
    pop_s   = out_valid_r && out_ready;
    full_s  = (level_r == LW'(DEPTH));
    wr_en_s = stage_valid_r && (!full_s || pop_s);
    drop_s  = stage_valid_r && full_s && !pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {OUT_W{1'b0}};
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= res_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != {LW{1'b0}});
    end
  end

  // Sticky flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      saturated_r <= 1'b0;
    end else begin
      overflow_r  <= drop_s || (overflow_r && !clr_flags);
      saturated_r <= (stage_valid_r && sat_s) || (saturated_r && !clr_flags);
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_valid_r ? mem_r[rd_ptr_r] : {OUT_W{1'b0}};
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign saturated  = saturated_r;

endmodule

// File: tb/tb_fir_decimator_out.sv
// Directed bench for fir_decimator_out (LOG2_N=2, OUT_SHIFT=2, OUT_W=8, DEPTH=4).
module tb_fir_decimator_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        saturated;
  logic        clr_flags;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  fir_decimator_out #(
    .IN_W(16), .OUT_W(8), .LOG2_N(2), .OUT_SHIFT(2), .DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .overflow(overflow), .saturated(saturated),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic block(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  // Called right after the dump edge: checks latency, head value, then lets it pop.
  task automatic expect_out(input string tag, input int exp);
    check({tag, "_lat0"}, int'(out_valid), 0);
    tick();
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'($signed(out_data)), exp);
    tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b1;
    clr_flags = 1'b0;
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_sat", int'(saturated), 0);
    reset_n = 1'b1;
    tick();

    // 1. basic average
    block(100);
    expect_out("avg100", 25);
    check("avg100_sat", int'(saturated), 0);
    check("avg100_empty", int'(out_valid), 0);

    // 2. rounding
    send(1); send(2); send(3); send(4);
    expect_out("ramp", 1);
    block(-2);
    expect_out("neg2", 0);
    block(-100);
    expect_out("neg100", -25);
    check("round_sat", int'(saturated), 0);

    // 3. saturation
    block(32767);
    expect_out("satmax", 127);
    check("satmax_flag", int'(saturated), 1);
    block(-32768);
    expect_out("satmin", -128);
    pulse_clr();
    check("sat_clr", int'(saturated), 0);

    // 4. backpressure and overflow
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) block(40);
    tick();
    tick();
    check("bp_level", int'(fifo_level), 4);
    check("bp_ovf", int'(overflow), 1);
    check("bp_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", int'(out_valid), 1);
      check("bp_drain_data", int'($signed(out_data)), 10);
      tick();
    end
    check("bp_empty_valid", int'(out_valid), 0);
    check("bp_empty_data", int'(out_data), 0);
    check("bp_empty_level", int'(fifo_level), 0);
    pulse_clr();
    check("ovf_clr", int'(overflow), 0);

    // 5. push into full FIFO with simultaneous pop
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) block(4 * k);
    tick();
    check("full_level", int'(fifo_level), 4);
    block(20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_level", int'(fifo_level), 4);
    check("pp_ovf", int'(overflow), 0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("pp_order", int'($signed(out_data)), k);
      tick();
    end
    check("pp_empty", int'(out_valid), 0);

    // 6. reset mid-block, then gapped input
    send(999);
    send(999);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mrst_level", int'(fifo_level), 0);
    for (int i = 0; i < 4; i++) begin
      send(10);
      if (i < 3) repeat (i + 1) tick();
    end
    expect_out("mrst_out", 3);
    check("mrst_nostale", int'(out_valid), 0);
    check("mrst_level_end", int'(fifo_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
